// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle control sequencer for a simple in-order core. It steps each
// instruction through FETCH -> EXEC -> (MEM) -> WB, owns the program counter,
// the instruction register and the retired-instruction counter, and stops in
// HALT on a halt instruction or in ERR when a memory access times out.
//
// Parameters
//   XLEN      datapath / PC width
//   RESET_PC  PC value loaded on reset
//   MAX_WAIT  wait cycles tolerated before a bus error (0 = no timeout)
//   CNT_W     width of the retired-instruction counter
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata     instruction fetch handshake
//   ir                          latched instruction for the decoder
//   is_load/is_store/is_halt/reg_we  decoder outputs for ir
//   npc                         next PC from the NPC generator
//   dmem_req/we/ack             data memory handshake
//   ld_capture                  load-data register capture strobe
//   rf_we                       register file write enable (1-cycle pulse)
//   pc                          current program counter
//   halted, bus_err             terminal status flags
//   retired                     retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module core_sequencer #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               MAX_WAIT = 16,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             reg_we,
    input  logic [XLEN-1:0]  npc,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ld_capture,
    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam bit TIMEOUT_EN = (MAX_WAIT > 0);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   pc_reg, pc_next;
    logic [31:0]       ir_reg, ir_next;
    logic [CNT_W-1:0]  retired_reg, retired_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            retired_reg <= '0;
            wait_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
            wait_reg    <= wait_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        retired_next = retired_reg;
        wait_next    = wait_reg;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ld_capture   = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        bus_err      = 1'b0;

        unique case (state_reg)
            FETCH: begin
                // Reset forces FETCH asynchronously; keep the request quiet
                // until reset is actually released.
                imem_req = ~rst;
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = EXEC;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                    // The count already equals the limit: MAX_WAIT unanswered
                    // cycles have passed and this one is unanswered too.
                    if (TIMEOUT_EN && (wait_reg == WAIT_LIMIT)) begin
                        state_next = ERR;
                    end
                end
            end
            EXEC: begin
                // Clearing here covers every entry into MEM.
                wait_next = '0;
                if (is_halt) begin
                    retired_next = retired_reg + CNT_W'(1);
                    state_next   = HALT;
                end else if (is_load || is_store) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    ld_capture = is_load;
                    state_next = WB;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                    if (TIMEOUT_EN && (wait_reg == WAIT_LIMIT)) begin
                        state_next = ERR;
                    end
                end
            end
            WB: begin
                // Clearing here covers every entry into FETCH after reset.
                wait_next    = '0;
                rf_we        = reg_we & ~is_store;
                pc_next      = npc;
                retired_next = retired_reg + CNT_W'(1);
                state_next   = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            ERR: begin
                bus_err = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign retired   = retired_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer
//
// Directed bench for core_sequencer (RESET_PC=0x100, MAX_WAIT=4). Walks an
// ALU op, a load with two wait cycles, a store, a fetch timeout, an ack on
// the last allowed cycle, a halt, and a reset during a data access.
// ---------------------------------------------------------------------------
module tb_core_sequencer;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [31:0]      ir;
    logic             is_load, is_store, is_halt, reg_we;
    logic [XLEN-1:0]  npc;
    logic             dmem_req, dmem_we, dmem_ack;
    logic             ld_capture, rf_we;
    logic [XLEN-1:0]  pc;
    logic             halted, bus_err;
    logic [CNT_W-1:0] retired;

    int vectors    = 0;
    int miscompares = 0;

    core_sequencer #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0100),
        .MAX_WAIT (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_halt    (is_halt),
        .reg_we     (reg_we),
        .npc        (npc),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ld_capture (ld_capture),
        .rf_we      (rf_we),
        .pc         (pc),
        .halted     (halted),
        .bus_err    (bus_err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Sequential NPC generator model.
    assign npc = pc + 32'd4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic hl, input logic we);
        is_load  = ld;
        is_store = st;
        is_halt  = hl;
        reg_we   = we;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=0x%0h exp=0x%0h", vectors, tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        set_dec(0, 0, 0, 0);

        // Reset state
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_ir", ir, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);
        chk("rst_bus_err", bus_err, 0);
        tick();
        tick();
        rst = 1'b0;

        // ALU op, immediate fetch ack
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        #1;
        chk("first_fetch_req", imem_req, 1);
        chk("first_fetch_addr", imem_addr, 32'h100);
        tick();
        imem_ack = 1'b0;
        set_dec(0, 0, 0, 1);
        #1;
        chk("alu_ir", ir, 32'h13);
        chk("exec_imem_req", imem_req, 0);
        chk("exec_dmem_req", dmem_req, 0);
        tick();
        #1;
        chk("alu_rf_we", rf_we, 1);
        chk("alu_pc_in_wb", pc, 32'h100);
        tick();
        set_dec(0, 0, 0, 0);
        #1;
        chk("alu_pc", pc, 32'h104);
        chk("alu_retired", retired, 1);
        chk("alu_rf_we_drop", rf_we, 0);
        chk("alu_refetch", imem_req, 1);

        // Load, two MEM wait cycles
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_2003;
        tick();
        imem_ack = 1'b0;
        set_dec(1, 0, 0, 1);
        dmem_ack = 1'b1;        // stray ack in EXEC must be ignored
        #1;
        chk("exec_ld_capture", ld_capture, 0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("ld_dmem_req_w1", dmem_req, 1);
        chk("ld_dmem_we", dmem_we, 0);
        chk("ld_capture_w1", ld_capture, 0);
        tick();
        #1;
        chk("ld_dmem_req_w2", dmem_req, 1);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("ld_capture_ack", ld_capture, 1);
        chk("ld_rf_we_in_mem", rf_we, 0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("ld_capture_drop", ld_capture, 0);
        chk("ld_rf_we", rf_we, 1);
        chk("ld_wb_dmem_req", dmem_req, 0);
        tick();
        set_dec(0, 0, 0, 0);
        #1;
        chk("ld_pc", pc, 32'h108);
        chk("ld_retired", retired, 2);

        // Store with reg_we high (write-back must still be suppressed)
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_2023;
        tick();
        imem_rdata = 32'hDEAD_BEEF;  // ack held into EXEC must not reload ir
        set_dec(0, 1, 0, 1);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("st_ir_kept", ir, 32'h2023);
        chk("st_dmem_req", dmem_req, 1);
        chk("st_dmem_we_w1", dmem_we, 1);
        tick();
        #1;
        chk("st_dmem_we_w2", dmem_we, 1);
        dmem_ack = 1'b1;
        #1;
        chk("st_ld_capture", ld_capture, 0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("st_rf_we", rf_we, 0);
        tick();
        set_dec(0, 0, 0, 0);
        #1;
        chk("st_pc", pc, 32'h10C);
        chk("st_retired", retired, 3);

        // Fetch timeout: four unanswered cycles tolerated, fifth errors
        repeat (4) tick();
        chk("to_still_fetch", imem_req, 1);
        chk("to_no_err_yet", bus_err, 0);
        tick();
        chk("to_bus_err", bus_err, 1);
        chk("to_imem_req", imem_req, 0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        tick();
        tick();
        imem_ack = 1'b0;
        #1;
        chk("err_sticky", bus_err, 1);
        chk("err_ir_frozen", ir, 32'h2023);
        chk("err_pc_frozen", pc, 32'h10C);
        chk("err_retired_frozen", retired, 3);

        // Reset out of ERR
        rst = 1'b1;
        #1;
        chk("rst2_bus_err", bus_err, 0);
        chk("rst2_pc", pc, 32'h100);
        chk("rst2_retired", retired, 0);
        chk("rst2_imem_req", imem_req, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_first_req", imem_req, 1);

        // Ack arriving on the last allowed fetch cycle wins over the timeout
        repeat (4) tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0093;
        tick();
        imem_ack = 1'b0;
        set_dec(0, 0, 0, 1);
        #1;
        chk("limit_ack_ir", ir, 32'h93);
        chk("limit_ack_no_err", bus_err, 0);
        tick();
        tick();
        set_dec(0, 0, 0, 0);
        #1;
        chk("limit_pc", pc, 32'h104);

        // Halt (also flagged as load: halt has priority)
        imem_ack   = 1'b1;
        imem_rdata = 32'h0010_0073;
        tick();
        imem_ack = 1'b0;
        set_dec(1, 0, 1, 1);
        tick();
        #1;
        chk("halt_halted", halted, 1);
        chk("halt_retired", retired, 2);
        chk("halt_pc", pc, 32'h104);
        chk("halt_dmem_req", dmem_req, 0);
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            tick();
            chk("halt_no_imem_req", imem_req, 0);
        end
        imem_ack = 1'b0;
        chk("halt_ir_frozen", ir, 32'h0010_0073);
        chk("halt_retired_frozen", retired, 2);
        rst = 1'b1;
        #1;
        chk("halt_rst_pc", pc, 32'h100);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_retired", retired, 0);
        tick();
        rst = 1'b0;
        set_dec(0, 0, 0, 0);

        // ALU, then reset in the middle of a load's MEM phase
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;
        set_dec(0, 0, 0, 1);
        tick();
        tick();
        set_dec(0, 0, 0, 0);
        #1;
        chk("pre_mem_pc", pc, 32'h104);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_2003;
        tick();
        imem_ack = 1'b0;
        set_dec(1, 0, 0, 1);
        tick();
        chk("mid_mem_dmem_req", dmem_req, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_dmem_req", dmem_req, 0);
        chk("mid_rst_pc", pc, 32'h100);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_rf_we", rf_we, 0);
        tick();
        rst = 1'b0;
        dmem_ack = 1'b1;        // late data ack after the abandoned access
        tick();
        dmem_ack = 1'b0;
        tick();
        chk("post_rst_rf_we", rf_we, 0);
        chk("post_rst_pc", pc, 32'h100);
        chk("post_rst_fetch", imem_req, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter MAX_WAIT, default 16, maximum memory wait cycles before bus error; 0 disables the timeout.
REQ-004 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  XLEN  fetch address, equals pc.
REQ-009 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 ir  output  32  latched instruction, fed to the decoder.
REQ-012 is_load, is_store, is_halt, reg_we  input  1 each  decoder outputs for ir.
REQ-013 npc  input  XLEN  next PC from the NPC generator.
REQ-014 dmem_req  output  1  data memory request.
REQ-015 dmem_we  output  1  data memory write strobe.
REQ-016 dmem_ack  input  1  data access complete.
REQ-017 ld_capture  output  1  pulse telling the load-data register to capture memory data.
REQ-018 rf_we  output  1  register file write enable, one-cycle pulse.
REQ-019 pc  output  XLEN  current program counter.
REQ-020 halted  output  1  core stopped by a halt instruction.
REQ-021 bus_err  output  1  core stopped by a memory timeout.
REQ-022 retired  output  CNT_W  count of retired instructions.

Function
REQ-023 The FSM SHALL have states FETCH, EXEC, MEM, WB, HALT and ERR.
REQ-024 FETCH: imem_req=1; on imem_ack, ir<=imem_rdata and next state is EXEC; otherwise stay in FETCH.
REQ-025 EXEC: one settle cycle with no requests; is_halt goes to HALT, is_load or is_store goes to MEM, else WB; is_halt has priority.
REQ-026 MEM: dmem_req=1 and dmem_we=is_store; on dmem_ack, ld_capture=is_load and next state is WB.
REQ-027 WB: rf_we=reg_we & ~is_store; pc<=npc; retired increments by 1; next state is FETCH.
REQ-028 HALT: retired increments once on entry; halted=1; pc and ir frozen; no requests; terminal until rst.
REQ-029 ERR: bus_err=1; no requests; pc, ir and retired frozen; terminal until rst.
REQ-030 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the request is high without ack.
REQ-031 When MAX_WAIT>0 and the counter reaches MAX_WAIT with no ack that cycle, the next state SHALL be ERR; an ack on that same cycle wins.
REQ-032 The wait counter width SHALL be $clog2(MAX_WAIT+1), with a minimum of 1.
REQ-033 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-034 imem_req, dmem_req, dmem_we, rf_we and ld_capture SHALL be Moore/state-decoded with no combinational path from ack inputs, except ld_capture, which is qualified by dmem_ack.
REQ-035 retired SHALL wrap modulo 2^CNT_W.
REQ-036 Minimum latency is 3 cycles per ALU instruction (FETCH with immediate ack, EXEC, WB) and 4 cycles per load/store.

Reset
REQ-037 On rst assertion, asynchronously: state=FETCH, pc=RESET_PC, ir=0, retired=0, wait counter=0.
REQ-038 During reset: all request and strobe outputs 0, halted=0, bus_err=0.
REQ-039 Reset asserted mid-access SHALL abandon the access with no write-back and no PC update.
REQ-040 After rst deasserts, the first fetch request is issued in the first cycle.

Verification
REQ-041 ALU op, imem_ack immediate, reg_we=1, npc=pc+4 -> rf_we pulses in cycle 3, pc 0->4, retired=1.
REQ-042 Load with dmem_ack after 2 wait cycles -> dmem_we=0, ld_capture is a single pulse, rf_we pulses the next cycle, 6 cycles total.
REQ-043 Store with reg_we=0 -> dmem_we=1 throughout MEM, rf_we stays 0, pc advances.
REQ-044 MAX_WAIT=4 and imem_ack held low -> ERR after 4 wait cycles, bus_err=1, imem_req=0; a late imem_ack is ignored.
REQ-045 Halt instruction -> halted=1, retired incremented by 1, no further imem_req for 20 cycles; rst returns pc to RESET_PC.
REQ-046 rst pulsed while in MEM -> dmem_req drops immediately, pc=RESET_PC, retired=0, no rf_we.
